// File: rtl/elbeth_mem_arbiter.sv
// elbeth_mem_arbiter
// Shares one single-port memory between the core's instruction-fetch port and
// its data port. Exactly one memory transaction is in flight at a time. The
// memory-side signals are registered at grant and held until the memory
// acknowledges or the access times out.
//
// Handshake semantics (both requester ports and the memory port):
//   - A requester raises *_req with stable command fields and holds both until
//     it sees its one-cycle *_ready pulse. At the edge that ends the *_ready
//     cycle it may drop *_req or present a new command.
//   - *_r_data and *_err are meaningful only in the *_ready cycle. *_r_data
//     keeps its last value otherwise.
//   - mem_req stays high with constant mem_* fields until the cycle in which
//     mem_ack = 1. mem_ack is ignored whenever the arbiter is not in a grant state.
//
// dbg_state exposes the FSM state: 0 = IDLE, 1 = GNT_I, 2 = GNT_D, 3 = DONE.
// DATA_W must be 32, because the byte-enable mask is four lanes wide.

module elbeth_mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int D_STREAK = 4,
  parameter int TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              rst,
  // instruction-fetch port
  input  logic              imem_req,
  input  logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_r_data,
  output logic              imem_ready,
  output logic              imem_err,
  // data port
  input  logic              dmem_req,
  input  logic              dmem_we,
  input  logic [ADDR_W-1:0] dmem_addr,
  input  logic [DATA_W-1:0] dmem_w_data,
  input  logic [3:0]        dmem_data_size,
  output logic [DATA_W-1:0] dmem_r_data,
  output logic              dmem_ready,
  output logic              dmem_err,
  // shared memory port
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [DATA_W-1:0] mem_w_data,
  input  logic [DATA_W-1:0] mem_r_data,
  input  logic              mem_ack,
  // debug visibility of the FSM
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GNT_I = 2'd1,
    S_GNT_D = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] STREAK_MAX = 4'(D_STREAK);
  // The timeout counter holds (cycles already spent in GNT_*) and starts at 0.
  // The last permitted grant cycle therefore sees the value TIMEOUT-1.
  localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);

  state_t              state_q, state_d;
  logic [3:0]          streak_q, streak_d;
  logic [7:0]          tmo_q, tmo_d;

  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [3:0]          mem_be_q, mem_be_d;
  logic [DATA_W-1:0]   mem_w_data_q, mem_w_data_d;

  logic                imem_ready_q, imem_ready_d;
  logic                imem_err_q, imem_err_d;
  logic [DATA_W-1:0]   imem_r_data_q, imem_r_data_d;
  logic                dmem_ready_q, dmem_ready_d;
  logic                dmem_err_q, dmem_err_d;
  logic [DATA_W-1:0]   dmem_r_data_q, dmem_r_data_d;

  logic                fetch_turn;
  logic                d_mask_ok;
  logic                unused_imem_addr_lsbs;

  // Fetch addresses are word aligned, so the two low bits are never used.
  assign unused_imem_addr_lsbs = ^imem_addr[1:0];

  // The fetch overrides data priority once data has won D_STREAK grants in a
  // row while a fetch was waiting.
  assign fetch_turn = imem_req && (streak_q == STREAK_MAX);

  // Data masks that are allowed: single bytes, aligned halves, and full words.
  always_comb begin
    d_mask_ok = 1'b0;
    case (dmem_data_size)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: d_mask_ok = 1'b1;
      default:                   d_mask_ok = 1'b0;
    endcase
  end

  // Next-state and registered-output computation for the arbiter FSM.
  always_comb begin
    state_d       = state_q;
    streak_d      = streak_q;
    tmo_d         = tmo_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_be_d      = mem_be_q;
    mem_w_data_d  = mem_w_data_q;
    imem_r_data_d = imem_r_data_q;
    dmem_r_data_d = dmem_r_data_q;
    // The completion flags are single-cycle pulses, so they default low.
    imem_ready_d  = 1'b0;
    imem_err_d    = 1'b0;
    dmem_ready_d  = 1'b0;
    dmem_err_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (dmem_req && !fetch_turn) begin
          // A data grant only extends the streak while a fetch is waiting.
          streak_d = imem_req ? (streak_q + 4'd1) : 4'd0;
          if (d_mask_ok) begin
            state_d      = S_GNT_D;
            mem_req_d    = 1'b1;
            mem_we_d     = dmem_we;
            mem_addr_d   = dmem_addr;
            mem_be_d     = dmem_data_size;
            mem_w_data_d = dmem_w_data;
            tmo_d        = 8'd0;
          end else begin
            // A rejected access never reaches memory and completes at once.
            state_d      = S_DONE;
            dmem_ready_d = 1'b1;
            dmem_err_d   = 1'b1;
          end
        end else if (imem_req) begin
          streak_d     = 4'd0;
          state_d      = S_GNT_I;
          mem_req_d    = 1'b1;
          mem_we_d     = 1'b0;
          mem_addr_d   = {imem_addr[ADDR_W-1:2], 2'b00};
          mem_be_d     = 4'b1111;
          mem_w_data_d = '0;
          tmo_d        = 8'd0;
        end
      end

      S_GNT_I, S_GNT_D: begin
        if (mem_ack) begin
          state_d   = S_DONE;
          mem_req_d = 1'b0;
          tmo_d     = 8'd0;
          if (state_q == S_GNT_I) begin
            imem_ready_d  = 1'b1;
            imem_r_data_d = mem_r_data;
          end else begin
            dmem_ready_d  = 1'b1;
            if (!mem_we_q) begin
              dmem_r_data_d = mem_r_data;
            end
          end
        end else if (tmo_q == TMO_LAST) begin
          // The memory did not answer in time, so the access is abandoned
          // and reported as an error.
          state_d   = S_DONE;
          mem_req_d = 1'b0;
          tmo_d     = 8'd0;
          if (state_q == S_GNT_I) begin
            imem_ready_d = 1'b1;
            imem_err_d   = 1'b1;
          end else begin
            dmem_ready_d = 1'b1;
            dmem_err_d   = 1'b1;
          end
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end

      S_DONE: begin
        // One completion cycle. Requests present now are not arbitrated.
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers. Reset clears everything and drops mem_req immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      streak_q      <= 4'd0;
      tmo_q         <= 8'd0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_be_q      <= 4'd0;
      mem_w_data_q  <= '0;
      imem_ready_q  <= 1'b0;
      imem_err_q    <= 1'b0;
      imem_r_data_q <= '0;
      dmem_ready_q  <= 1'b0;
      dmem_err_q    <= 1'b0;
      dmem_r_data_q <= '0;
    end else begin
      state_q       <= state_d;
      streak_q      <= streak_d;
      tmo_q         <= tmo_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_be_q      <= mem_be_d;
      mem_w_data_q  <= mem_w_data_d;
      imem_ready_q  <= imem_ready_d;
      imem_err_q    <= imem_err_d;
      imem_r_data_q <= imem_r_data_d;
      dmem_ready_q  <= dmem_ready_d;
      dmem_err_q    <= dmem_err_d;
      dmem_r_data_q <= dmem_r_data_d;
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_be      = mem_be_q;
  assign mem_w_data  = mem_w_data_q;
  assign imem_ready  = imem_ready_q;
  assign imem_err    = imem_err_q;
  assign imem_r_data = imem_r_data_q;
  assign dmem_ready  = dmem_ready_q;
  assign dmem_err    = dmem_err_q;
  assign dmem_r_data = dmem_r_data_q;
  assign dbg_state   = state_q;

endmodule
